multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opCode  input  7  instruction opcode bits [6:0], from the instruction register.
REQ-005 fun3  input  3  instruction bits [14:12].
REQ-006 fun7  input  7  instruction bits [31:25].
REQ-007 br_taken  input  1  branch-compare result from the datapath, valid in EXEC.
REQ-008 mem_ready  input  1  memory completes the current request this cycle.
REQ-009 MemReq  output  1  memory request (fetch or data).
REQ-010 IRWr  output  1  load instruction register.
REQ-011 PCWr  output  1  write PC.
REQ-012 PCSrc  output  1  0 = PC+4, 1 = ALU result.
REQ-013 DMWr  output  1  data write qualifier on MemReq.
REQ-014 DMCtrl  output  3  access size/sign (fun3 of load/store).
REQ-015 ImmSrc  output  3  000 I, 001 S, 101 B, 110 J.
REQ-016 ALUASrc  output  1  0 = rs1, 1 = PC.
REQ-017 ALUBSrc  output  1  0 = rs2, 1 = immediate.
REQ-018 ALUOpcode  output  4  {fun7[5], fun3} for R-type and I-type shifts (fun3=101); {0, fun3} for other I-type; 0000 otherwise.
REQ-019 RUDataWrSrc  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-020 RUWr  output  1  register-file write enable.
REQ-021 illegal  output  1  sticky flag: unsupported opcode decoded.
REQ-022 state  output  3  current state encoding, for debug.

Function
REQ-023 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; 6 and 7 SHALL go to FETCH.
REQ-024 FETCH: MemReq=1; hold while mem_ready=0; on mem_ready=1 assert IRWr=1, PCWr=1, PCSrc=0 that cycle -> DECODE.
REQ-025 DECODE: SHALL latch all decoded control fields into registers; supported opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111 -> EXEC; any other -> TRAP.
REQ-026 EXEC: drive latched ALU controls; R/I -> WB; load/store -> MEM; branch: PCWr=br_taken, PCSrc=1 -> FETCH; jal/jalr: PCWr=1, PCSrc=1 -> WB.
REQ-027 MEM: MemReq=1, DMWr=1 for store only, DMCtrl=latched fun3; hold until mem_ready; then load -> WB, store -> FETCH.
REQ-028 WB: RUWr=1 for exactly one cycle with latched RUDataWrSrc -> FETCH.
REQ-029 TRAP: illegal=1; all enables 0; remain in TRAP until reset.
REQ-030 IRWr and PCWr in FETCH are the only outputs that depend combinationally on mem_ready; all others SHALL depend on state and latched fields only.
REQ-031 Latency with mem_ready tied high: branch 3 cycles; R, I, store, jal and jalr 4; load 5. Each wait cycle adds exactly 1.
REQ-032 RUWr, DMWr, PCWr and IRWr SHALL never be asserted outside the states named above.

Reset
REQ-033 rst_n low SHALL immediately force state=FETCH, illegal=0, latched fields=0, and all outputs 0 except MemReq, which rises only once rst_n is released.
REQ-034 Reset during MEM or WB SHALL suppress any pending DMWr or RUWr in the same cycle.

Structure
REQ-035 The shared package riscv_pkg SHALL hold the opcode constants, the state enum, and the ImmSrc and RUDataWrSrc encodings.
REQ-036 One combinational sub-module, instr_decoder (opCode/fun3/fun7 -> control fields plus a valid flag), SHALL be instantiated once; its outputs are registered in DECODE.

Verification
REQ-037 add (0110011, fun3=000, fun7=0000000), mem_ready=1 -> states 0,1,2,4,0; RUWr=1 only in WB; ALUOpcode=0000.
REQ-038 lw (fun3=010), mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles; WB with RUDataWrSrc=01; 7 cycles total.
REQ-039 beq with br_taken=0, then with br_taken=1 -> PCWr=0 in EXEC, then PCWr=1 with PCSrc=1; 3 cycles each.
REQ-040 opcode 1111111 -> TRAP, illegal=1, no further MemReq; rst_n pulse -> FETCH, illegal=0.
REQ-041 sw (fun3=000) with rst_n asserted in MEM -> DMWr drops the same cycle; state=0.
REQ-042 srai (0010011, fun3=101, fun7=0100000) -> ALUOpcode=1101, ALUBSrc=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Purpose: shared opcode constants, FSM state encoding and control-field encodings
//          for the multicycle RV32 control unit.
// Latency/backpressure: none (declarations only).
package riscv_pkg;

  // Supported major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // ImmSrc encodings
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  // RUDataWrSrc encodings
  localparam logic [1:0] RU_ALU = 2'b00;
  localparam logic [1:0] RU_MEM = 2'b01;
  localparam logic [1:0] RU_PC4 = 2'b10;

  // Instruction class, selects the path taken out of EXEC and MEM
  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;

  // fun3 of the shift-right group, where fun7[5] picks arithmetic vs logical
  localparam logic [2:0] F3_SR = 3'b101;

endpackage

// File: rtl/instr_decoder.sv
// Purpose: combinational opcode/fun3/fun7 decode into datapath control fields + valid.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent registers the outputs in DECODE.
// Ports: i_opcode/i_fun3/i_fun7 instruction fields in; o_valid (opcode supported),
//        o_cls (instruction class), o_imm_src, o_alu_a_src, o_alu_b_src, o_alu_op,
//        o_ru_src out.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_fun3,
  input  logic [6:0] i_fun7,
  output logic       o_valid,
  output logic [2:0] o_cls,
  output logic [2:0] o_imm_src,
  output logic       o_alu_a_src,
  output logic       o_alu_b_src,
  output logic [3:0] o_alu_op,
  output logic [1:0] o_ru_src
);

  // Only fun7[5] selects an ALU variant (sub / sra); the other bits are ignored.
  logic w_unused_fun7;
  assign w_unused_fun7 = ^{i_fun7[6], i_fun7[4:0]};

  always_comb begin
    o_valid     = 1'b0;
    o_cls       = CLS_ALU;
    o_imm_src   = IMM_I;
    o_alu_a_src = 1'b0;
    o_alu_b_src = 1'b0;
    o_alu_op    = 4'b0000;
    o_ru_src    = RU_ALU;
    case (i_opcode)
      OP_R: begin
        o_valid  = 1'b1;
        o_alu_op = {i_fun7[5], i_fun3};
      end
      OP_I: begin
        o_valid     = 1'b1;
        o_alu_b_src = 1'b1;
        // For I-type, fun7 is part of the immediate except on shifts
        o_alu_op    = (i_fun3 == F3_SR) ? {i_fun7[5], i_fun3} : {1'b0, i_fun3};
      end
      OP_LOAD: begin
        o_valid     = 1'b1;
        o_cls       = CLS_LOAD;
        o_alu_b_src = 1'b1;
        o_ru_src    = RU_MEM;
      end
      OP_STORE: begin
        o_valid     = 1'b1;
        o_cls       = CLS_STORE;
        o_imm_src   = IMM_S;
        o_alu_b_src = 1'b1;
      end
      OP_BRANCH: begin
        // ALU forms the target PC+imm; the comparison arrives as br_taken
        o_valid     = 1'b1;
        o_cls       = CLS_BRANCH;
        o_imm_src   = IMM_B;
        o_alu_a_src = 1'b1;
        o_alu_b_src = 1'b1;
      end
      OP_JAL: begin
        o_valid     = 1'b1;
        o_cls       = CLS_JUMP;
        o_imm_src   = IMM_J;
        o_alu_a_src = 1'b1;
        o_alu_b_src = 1'b1;
        o_ru_src    = RU_PC4;
      end
      OP_JALR: begin
        o_valid     = 1'b1;
        o_cls       = CLS_JUMP;
        o_alu_b_src = 1'b1;
        o_ru_src    = RU_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: multicycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Latency: branch 3, R/I/store/jal/jalr 4, load 5 cycles; +1 per mem_ready-low cycle.
// Backpressure: FETCH and MEM hold while mem_ready is low.
// Ports: clk, rst_n; opCode/fun3/fun7 from the IR; br_taken, mem_ready from datapath/memory;
//        memory (MemReq, DMWr, DMCtrl), PC/IR (PCWr, PCSrc, IRWr), ALU (ImmSrc, ALUASrc,
//        ALUBSrc, ALUOpcode) and register-file (RUDataWrSrc, RUWr) controls; illegal; state.
module multicycle_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opCode,
  input  logic [2:0] fun3,
  input  logic [6:0] fun7,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       IRWr,
  output logic       PCWr,
  output logic       PCSrc,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic [2:0] ImmSrc,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [3:0] ALUOpcode,
  output logic [1:0] RUDataWrSrc,
  output logic       RUWr,
  output logic       illegal,
  output logic [2:0] state
);

  state_t     r_state, w_next;
  logic       w_valid;
  logic [2:0] w_cls, w_imm_src;
  logic       w_alu_a_src, w_alu_b_src;
  logic [3:0] w_alu_op;
  logic [1:0] w_ru_src;

  logic [2:0] r_cls, r_imm_src, r_dm_ctrl;
  logic       r_alu_a_src, r_alu_b_src, r_illegal;
  logic [3:0] r_alu_op;
  logic [1:0] r_ru_src;

  instr_decoder u_dec (
    .i_opcode    (opCode),
    .i_fun3      (fun3),
    .i_fun7      (fun7),
    .o_valid     (w_valid),
    .o_cls       (w_cls),
    .o_imm_src   (w_imm_src),
    .o_alu_a_src (w_alu_a_src),
    .o_alu_b_src (w_alu_b_src),
    .o_alu_op    (w_alu_op),
    .o_ru_src    (w_ru_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  // Decoded fields are captured once in DECODE so later states see a stable copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls       <= CLS_ALU;
      r_imm_src   <= 3'b000;
      r_alu_a_src <= 1'b0;
      r_alu_b_src <= 1'b0;
      r_alu_op    <= 4'b0000;
      r_ru_src    <= 2'b00;
      r_dm_ctrl   <= 3'b000;
      r_illegal   <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_cls       <= w_cls;
      r_imm_src   <= w_imm_src;
      r_alu_a_src <= w_alu_a_src;
      r_alu_b_src <= w_alu_b_src;
      r_alu_op    <= w_alu_op;
      r_ru_src    <= w_ru_src;
      r_dm_ctrl   <= fun3;
      if (!w_valid) r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
  assign state   = r_state;

  always_comb begin
    w_next      = r_state;
    MemReq      = 1'b0;
    IRWr        = 1'b0;
    PCWr        = 1'b0;
    PCSrc       = 1'b0;
    DMWr        = 1'b0;
    DMCtrl      = 3'b000;
    ImmSrc      = 3'b000;
    ALUASrc     = 1'b0;
    ALUBSrc     = 1'b0;
    ALUOpcode   = 4'b0000;
    RUDataWrSrc = 2'b00;
    RUWr        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        MemReq = 1'b1;
        IRWr   = mem_ready;
        PCWr   = mem_ready;
        if (mem_ready) w_next = ST_DECODE;
      end
      ST_DECODE: w_next = w_valid ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        ImmSrc    = r_imm_src;
        ALUASrc   = r_alu_a_src;
        ALUBSrc   = r_alu_b_src;
        ALUOpcode = r_alu_op;
        case (r_cls)
          CLS_LOAD, CLS_STORE: w_next = ST_MEM;
          CLS_BRANCH: begin
            PCWr   = br_taken;
            PCSrc  = 1'b1;
            w_next = ST_FETCH;
          end
          CLS_JUMP: begin
            PCWr   = 1'b1;
            PCSrc  = 1'b1;
            w_next = ST_WB;
          end
          default: w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        MemReq = 1'b1;
        DMWr   = (r_cls == CLS_STORE);
        DMCtrl = r_dm_ctrl;
        if (mem_ready) w_next = (r_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        RUWr        = 1'b1;
        RUDataWrSrc = r_ru_src;
        w_next      = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
    // Nothing may be requested or written while reset is held, including the
    // mem_ready-driven FETCH strobes and MemReq itself.
    if (!rst_n) begin
      MemReq      = 1'b0;
      IRWr        = 1'b0;
      PCWr        = 1'b0;
      PCSrc       = 1'b0;
      DMWr        = 1'b0;
      DMCtrl      = 3'b000;
      ImmSrc      = 3'b000;
      ALUASrc     = 1'b0;
      ALUBSrc     = 1'b0;
      ALUOpcode   = 4'b0000;
      RUDataWrSrc = 2'b00;
      RUWr        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: self-checking bench for multicycle_control; per-cycle expected outputs are
//          queued with the stimulus and popped/compared as each cycle completes.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opCode = 7'b0;
  logic [2:0] fun3 = 3'b0;
  logic [6:0] fun7 = 7'b0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       MemReq, IRWr, PCWr, PCSrc, DMWr, ALUASrc, ALUBSrc, RUWr, illegal;
  logic [2:0] DMCtrl, ImmSrc, state;
  logic [3:0] ALUOpcode;
  logic [1:0] RUDataWrSrc;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .fun3(fun3), .fun7(fun7),
    .br_taken(br_taken), .mem_ready(mem_ready), .MemReq(MemReq), .IRWr(IRWr),
    .PCWr(PCWr), .PCSrc(PCSrc), .DMWr(DMWr), .DMCtrl(DMCtrl), .ImmSrc(ImmSrc),
    .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOpcode(ALUOpcode),
    .RUDataWrSrc(RUDataWrSrc), .RUWr(RUWr), .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       memreq;
    logic       irwr;
    logic       pcwr;
    logic       pcsrc;
    logic       dmwr;
    logic [2:0] dmctrl;
    logic [2:0] imm;
    logic       alua;
    logic       alub;
    logic [3:0] aluop;
    logic [1:0] rusrc;
    logic       ruwr;
    logic       ill;
  } outs_t;

  outs_t      exp_q[$];
  logic [1:0] stim_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic outs_t sample();
    outs_t t;
    t.st = state; t.memreq = MemReq; t.irwr = IRWr; t.pcwr = PCWr; t.pcsrc = PCSrc;
    t.dmwr = DMWr; t.dmctrl = DMCtrl; t.imm = ImmSrc; t.alua = ALUASrc; t.alub = ALUBSrc;
    t.aluop = ALUOpcode; t.rusrc = RUDataWrSrc; t.ruwr = RUWr; t.ill = illegal;
    return t;
  endfunction

  // Expected-value constructors, one per state
  function automatic outs_t x_fetch(input logic mr);
    outs_t t; t = '0; t.st = 3'd0; t.memreq = 1'b1; t.irwr = mr; t.pcwr = mr; return t;
  endfunction
  function automatic outs_t x_decode();
    outs_t t; t = '0; t.st = 3'd1; return t;
  endfunction
  function automatic outs_t x_exec(input logic [2:0] imm, input logic a, input logic b,
                                   input logic [3:0] op, input logic pcwr, input logic pcsrc);
    outs_t t; t = '0; t.st = 3'd2; t.imm = imm; t.alua = a; t.alub = b; t.aluop = op;
    t.pcwr = pcwr; t.pcsrc = pcsrc; return t;
  endfunction
  function automatic outs_t x_mem(input logic dmwr, input logic [2:0] ctl);
    outs_t t; t = '0; t.st = 3'd3; t.memreq = 1'b1; t.dmwr = dmwr; t.dmctrl = ctl; return t;
  endfunction
  function automatic outs_t x_wb(input logic [1:0] src);
    outs_t t; t = '0; t.st = 3'd4; t.ruwr = 1'b1; t.rusrc = src; return t;
  endfunction
  function automatic outs_t x_trap();
    outs_t t; t = '0; t.st = 3'd5; t.ill = 1'b1; return t;
  endfunction

  task automatic push(input logic mr, input logic bt, input outs_t e);
    stim_q.push_back({mr, bt});
    exp_q.push_back(e);
  endtask

  // Drives one cycle's stimulus just after the edge, samples at the falling edge
  task automatic run_cycle(output outs_t o, output outs_t e);
    logic [1:0] s;
    s = stim_q.pop_front();
    e = exp_q.pop_front();
    @(posedge clk); #1;
    mem_ready = s[1];
    br_taken  = s[0];
    @(negedge clk);
    o = sample();
  endtask

  task automatic test_reset();
    outs_t o, e;
    #1 rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    o = sample(); e = '0; checks++;
    if (o !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", o, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    o = sample(); e = x_fetch(1'b0); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_release: got %h expected %h", o, e); end
  endtask

  task automatic test_alu_ops();
    outs_t o, e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] eop;
    logic       eb;
    int         n;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; eop = 4'b0000; eb = 1'b0; end // add
        1:       begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; eop = 4'b1000; eb = 1'b0; end // sub
        2:       begin op = 7'b0010011; f3 = 3'b101; f7 = 7'b0100000; eop = 4'b1101; eb = 1'b1; end // srai
        3:       begin op = 7'b0010011; f3 = 3'b000; f7 = 7'b0100000; eop = 4'b0000; eb = 1'b1; end // addi
        4:       begin op = 7'b0110011; f3 = 3'b100; f7 = 7'b0000000; eop = 4'b0100; eb = 1'b0; end // xor
        default: begin op = 7'b0010011; f3 = 3'b111; f7 = 7'b0100000; eop = 4'b0111; eb = 1'b1; end // andi
      endcase
      opCode = op; fun3 = f3; fun7 = f7;
      push(1'b1, 1'b0, x_fetch(1'b1));
      push(1'b1, 1'b0, x_decode());
      push(1'b1, 1'b0, x_exec(3'b000, 1'b0, eb, eop, 1'b0, 1'b0));
      push(1'b1, 1'b0, x_wb(2'b00));
      n = 0;
      while (exp_q.size() != 0) begin
        run_cycle(o, e); checks++;
        if (o !== e) begin errors++; $display("FAIL alu[%0d] cycle %0d: got %h expected %h", i, n, o, e); end
        n++;
      end
    end
  endtask

  task automatic test_load_wait();
    outs_t o, e;
    int    n;
    opCode = 7'b0000011; fun3 = 3'b010; fun7 = 7'b0;
    push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b0, 1'b0, x_decode());
    push(1'b0, 1'b0, x_exec(3'b000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0));
    push(1'b0, 1'b0, x_mem(1'b0, 3'b010));
    push(1'b0, 1'b0, x_mem(1'b0, 3'b010));
    push(1'b1, 1'b0, x_mem(1'b0, 3'b010));
    push(1'b0, 1'b0, x_wb(2'b01));
    n = 0;
    while (exp_q.size() != 0) begin
      run_cycle(o, e); checks++;
      if (o !== e) begin errors++; $display("FAIL lw cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_store_fetch_wait();
    outs_t o, e;
    int    n;
    opCode = 7'b0100011; fun3 = 3'b001; fun7 = 7'b0;
    push(1'b0, 1'b0, x_fetch(1'b0));
    push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b1, 1'b0, x_decode());
    push(1'b1, 1'b0, x_exec(3'b001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0));
    push(1'b1, 1'b0, x_mem(1'b1, 3'b001));
    push(1'b0, 1'b0, x_fetch(1'b0));
    n = 0;
    while (exp_q.size() != 0) begin
      run_cycle(o, e); checks++;
      if (o !== e) begin errors++; $display("FAIL sh cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_branch();
    outs_t o, e;
    int    n;
    opCode = 7'b1100011; fun3 = 3'b000; fun7 = 7'b0;
    for (int bt = 0; bt < 2; bt++) begin
      push(1'b1, bt[0], x_fetch(1'b1));
      push(1'b0, bt[0], x_decode());
      push(1'b0, bt[0], x_exec(3'b101, 1'b1, 1'b1, 4'b0000, bt[0], 1'b1));
      n = 0;
      while (exp_q.size() != 0) begin
        run_cycle(o, e); checks++;
        if (o !== e) begin errors++; $display("FAIL beq taken=%0d cycle %0d: got %h expected %h", bt, n, o, e); end
        n++;
      end
    end
  endtask

  task automatic test_jump();
    outs_t o, e;
    int    n;
    for (int j = 0; j < 2; j++) begin
      if (j == 0) begin
        opCode = 7'b1101111; fun3 = 3'b011; fun7 = 7'b0100000;
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode());
        push(1'b1, 1'b0, x_exec(3'b110, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1));
      end else begin
        opCode = 7'b1100111; fun3 = 3'b000; fun7 = 7'b0;
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode());
        push(1'b1, 1'b0, x_exec(3'b000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1));
      end
      push(1'b1, 1'b0, x_wb(2'b10));
      n = 0;
      while (exp_q.size() != 0) begin
        run_cycle(o, e); checks++;
        if (o !== e) begin errors++; $display("FAIL jump[%0d] cycle %0d: got %h expected %h", j, n, o, e); end
        n++;
      end
    end
  endtask

  task automatic test_reset_in_mem();
    outs_t o, e;
    int    n;
    opCode = 7'b0100011; fun3 = 3'b000; fun7 = 7'b0;
    push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b0, 1'b0, x_decode());
    push(1'b0, 1'b0, x_exec(3'b001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0));
    push(1'b0, 1'b0, x_mem(1'b1, 3'b000));
    n = 0;
    while (exp_q.size() != 0) begin
      run_cycle(o, e); checks++;
      if (o !== e) begin errors++; $display("FAIL sw cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    o = sample(); e = '0; checks++;
    if (o !== e) begin errors++; $display("FAIL sw_reset_in_mem: got %h expected %h", o, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    o = sample(); e = x_fetch(1'b0); checks++;
    if (o !== e) begin errors++; $display("FAIL sw_after_reset: got %h expected %h", o, e); end
  endtask

  task automatic test_illegal();
    outs_t o, e;
    int    n;
    opCode = 7'b1111111; fun3 = 3'b000; fun7 = 7'b0;
    push(1'b1, 1'b0, x_fetch(1'b1));
    push(1'b1, 1'b0, x_decode());
    for (int k = 0; k < 4; k++) push(1'b1, 1'b1, x_trap());
    n = 0;
    while (exp_q.size() != 0) begin
      run_cycle(o, e); checks++;
      if (o !== e) begin errors++; $display("FAIL illegal cycle %0d: got %h expected %h", n, o, e); end
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    o = sample(); e = '0; checks++;
    if (o !== e) begin errors++; $display("FAIL illegal_reset: got %h expected %h", o, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    o = sample(); e = x_fetch(1'b0); checks++;
    if (o !== e) begin errors++; $display("FAIL illegal_release: got %h expected %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_wait();
    test_store_fetch_wait();
    test_branch();
    test_jump();
    test_reset_in_mem();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
